// File: rtl/uart_loopback_fifo.sv
// Byte FIFO and transmit scheduler sitting between uart_rx and UART_tx in the loopback path.
// Received bytes are queued so back-to-back frames survive while the transmitter is still shifting.
module uart_loopback_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_tx_busy,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t              state, state_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wptr, rptr;
    logic [ADDR_W:0]     count;
    logic                push, pop;

    assign o_count = count;
    assign o_full  = (count == FULL_COUNT);
    assign o_empty = (count == '0);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        pop        = (state == IDLE) && !o_empty && !i_tx_busy;
        push       = i_rx_done && (!o_full || pop);
        case (state)
            IDLE:      if (pop) state_next = START;
            START:     state_next = WAIT_DONE;
            WAIT_DONE: if (i_tx_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_next;
            o_tx_start <= pop;
            o_overflow <= i_rx_done && !push;
            if (push) wptr <= wptr + ADDR_W'(1);
            if (pop) begin
                rptr      <= rptr + ADDR_W'(1);
                o_tx_data <= mem[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; contents are only ever read after being written.
    // When full with a simultaneous pop, wptr == rptr and the read above still sees the old byte.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= i_rx_data;
    end

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Randomized scoreboard bench for uart_loopback_fifo with a behavioural transmitter stub.
// A queue-based reference model predicts occupancy, start pulses and overflow each cycle.
module tb_uart_loopback_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int FRAME  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_done = 1'b0;
    logic              tx_done = 1'b0;
    logic              stub_busy = 1'b0;
    logic              hold_busy = 1'b0;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              full, empty, overflow;
    logic [ADDR_W:0]   count;

    assign tx_busy = stub_busy | hold_busy;

    uart_loopback_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_tx_busy  (tx_busy),
        .i_tx_done  (tx_done),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: occupancy counter, scheduler phase (0 free, 1 just started, 2 in frame),
    // and a scoreboard of accepted bytes in arrival order.
    logic [DATA_W-1:0] sb_q[$];
    int                m_count = 0;
    int                m_phase = 0;
    bit                m_start = 1'b0;
    bit                m_ovf = 1'b0;
    bit                m_pop, m_push;
    bit                started = 1'b0;
    logic [DATA_W-1:0] last_data = '0;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst) begin
            m_count   = 0;
            m_phase   = 0;
            m_start   = 1'b0;
            m_ovf     = 1'b0;
            last_data = '0;
            sb_q.delete();
        end else begin
            m_pop   = (m_phase == 0) && (m_count > 0) && !tx_busy;
            m_push  = rx_done && ((m_count < DEPTH) || m_pop);
            m_start = m_pop;
            m_ovf   = rx_done && !m_push;
            if (m_push) sb_q.push_back(rx_data);
            m_count = m_count + int'(m_push) - int'(m_pop);
            if (m_pop)                       m_phase = 1;
            else if (m_phase == 1)           m_phase = 2;
            else if (m_phase == 2 && tx_done) m_phase = 0;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each start pulse.
    always @(negedge clk) begin
        if (started) begin
            check("count", 32'(count), 32'(m_count));
            check("empty", 32'(empty), 32'(m_count == 0));
            check("full", 32'(full), 32'(m_count == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("tx_start", 32'(tx_start), 32'(m_start));
            if (tx_start === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: start with data %0h but no byte expected", tx_data);
                end else begin
                    last_data = sb_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(last_data));
                end
            end else begin
                check("tx_data_hold", 32'(tx_data), 32'(last_data));
            end
        end
    end

    // Transmitter stub: busy for FRAME cycles after each start, then a one-cycle done.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                stub_busy = 1'b1;
                repeat (FRAME) @(negedge clk);
                stub_busy = 1'b0;
                tx_done   = 1'b1;
                @(negedge clk);
                tx_done   = 1'b0;
            end
        end
    end

    task automatic push_seq(input logic [DATA_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_data = first + DATA_W'(i);
            rx_done = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_count != 0 || m_phase != 0 || stub_busy || sb_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_time", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int n;
        int starts;

        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: start pulse two edges after the write strobe.
        push_seq(8'h32, 1);
        @(negedge clk);
        check("single_latency_start", 32'(tx_start), 32'd1);
        check("single_latency_data", 32'(tx_data), 32'h32);
        wait_idle();
        check("single_count_after", 32'(count), 32'd0);

        // Burst while transmitter busy, then drain in order.
        hold_busy = 1'b1;
        push_seq(8'h30, 8);
        check("burst_count", 32'(count), 32'd8);
        hold_busy = 1'b0;
        wait_idle();

        // Fill to 16, 17th is dropped with an overflow pulse.
        hold_busy = 1'b1;
        push_seq(8'h40, 17);
        check("full_overflow_pulse", 32'(overflow), 32'd1);
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd16);

        // Write in the same cycle a pop fires while full: accepted, no overflow.
        @(negedge clk);
        hold_busy = 1'b0;
        rx_data   = 8'hA5;
        rx_done   = 1'b1;
        @(negedge clk);
        rx_done   = 1'b0;
        check("simul_count", 32'(count), 32'd16);
        check("simul_no_overflow", 32'(overflow), 32'd0);
        check("simul_start", 32'(tx_start), 32'd1);
        wait_idle();

        // Random traffic with occasional busy hold-offs; pointers wrap several times.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx_data   = DATA_W'($urandom);
            rx_done   = 1'b1;
            hold_busy = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            rx_done   = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        hold_busy = 1'b0;
        wait_idle();

        // Reset while a frame is in flight and bytes are still queued.
        push_seq(8'h60, 3);
        n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_start_seen", 32'(n < 50), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'h00);
        check("midrst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        starts = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_start === 1'b1) starts++;
        end
        check("no_start_after_reset", 32'(starts), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
